add_subt_serial_responder: RTL and testbench
============================================

// Module: add_subt_serial_responder
// PURPOSE
//  Responder end of the beg_add_subt / ready_add_subt / ack_add_subt handshake that the CORDIC control FSM
//  drives. It accepts two operands and an add/subtract select, then computes the result over several cycles.
//  The sum is built one CHUNK-bit slice per cycle with a registered carry.
//  It presents the result with ready_add_subt and holds it until the initiator acknowledges.
//  It sits between the CORDIC datapath muxes and the Xn/Yn/Zn result registers.
// PARAMETERS
//  W      32  operand/result width, two's complement; must be an integer multiple of CHUNK
//  CHUNK   8  bits added per CALC cycle; N = W/CHUNK calc cycles (CHUNK==W gives N=1)
// PORTS
//  clk                 in   1  system clock, rising edge
//  reset               in   1  asynchronous, active-low reset
//  beg_add_subt        in   1  start request, sampled only in IDLE
//  ack_add_subt        in   1  result accepted, sampled only in DONE
//  operation_add_subt  in   1  0 = A+B, 1 = A-B; sampled with beg_add_subt
//  data_a              in   W  operand A; sampled with beg_add_subt
//  data_b              in   W  operand B; sampled with beg_add_subt
//  ready_add_subt      out  1  result valid; level, held until ack
//  result              out  W  A+B or A-B, modulo 2^W
//  overflow            out  1  signed overflow of the last operation, valid with ready
//  busy                out  1  high in CALC and DONE
// BEHAVIOUR
//  Reset (reset==0, async)
//   - state=IDLE; all outputs 0.
//   - Operand, carry and slice-index registers are cleared.
//  States
//   - IDLE -> CALC: on beg_add_subt==1.
//     Latch opA=data_a, opB=data_b^{W{op}}, carry=op, idx=0.
//   - CALC: each cycle, for slice idx: {c, s} = opA[idx] + opB[idx] + carry.
//     Write s into result slice idx, register c, idx++.
//   - CALC -> DONE: after the slice with idx==N-1 is written.
//     overflow = (opA[W-1] == opB[W-1]) && (result[W-1] != opA[W-1]).
//   - DONE: ready_add_subt=1; result and overflow held stable.
//   - DONE -> IDLE: on ack_add_subt==1; ready_add_subt drops at that edge.
//  Latency
//   - beg sampled at edge 0.
//   - ready_add_subt high after edge N+1; N+2 edges after beg for N=4 is wrong, it is exactly N+1.
//  Handshake rules
//   - beg in CALC or DONE is ignored; operands and op are not resampled.
//   - ack outside DONE is ignored.
//   - beg and ack both high in DONE: ack wins, go IDLE, beg is NOT accepted.
//     The initiator re-asserts beg; earliest new start is the following edge.
//   - Back-to-back: beg may be high the cycle after the ack edge.
//   - No timeout: DONE is held indefinitely without ack.
//  Output behaviour
//   - result and overflow keep their last values in IDLE; only reset clears them.
//   - Intermediate slices of result change during CALC; result is valid only with ready.
//  Reset mid-operation
//   - Immediate abort to IDLE with all outputs 0; no partial result is retained.
//  Width rules
//   - No sign extension; carry-out of the MSB is discarded.
//   - Subtraction is A + ~B + 1 via the initial carry.
// TESTING (W=32, CHUNK=8, N=4)
//  1. beg with op=0, A=0x00000005, B=0x00000003 -> ready at edge 5 after beg, result=0x00000008, overflow=0,
//     busy high edges 1..; ack held 2 cycles, ready drops on ack edge.
//  2. Slice carry: A=0x000000FF + B=0x00000001 -> 0x00000100.
//     Sub A=0x00000000 - B=0x00000001 -> 0xFFFFFFFF, overflow=0.
//  3. Overflow: 0x7FFFFFFF + 0x00000001 -> 0x80000000, ovf=1.
//     0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf=1.
//     0xFFFFFFFF + 0xFFFFFFFF -> 0xFFFFFFFE, ovf=0.
//  4. Pulse beg with new operands during CALC and during DONE, and hold DONE 10 cycles without ack
//     -> result and overflow unchanged, ready stays 1, no restart.
//  5. beg and ack both high in DONE -> IDLE, ready=0, busy=0, no new op.
//     beg on the next cycle -> new result after N+1 edges.
//  6. Assert reset at CALC idx=2 -> ready, result, overflow and busy go to 0 without waiting for clk.
//     After release, test 1 passes unchanged.

Source files
------------

// File: rtl/add_subt_serial_responder.sv
// Serial add/subtract responder for the CORDIC beg/ready/ack handshake.
// Adds CHUNK bits per cycle with a registered carry and holds the result until ack.
`timescale 1ns/1ps
module add_subt_serial_responder #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         operation_add_subt,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         ready_add_subt,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for beg_add_subt
  // CALC  | adding slice idx, one slice per cycle
  // FIN   | all slices written, overflow resolved from the final sign bit
  // DONE  | result presented with ready, waiting for ack
  localparam int N     = W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK:0]   slice_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (beg_add_subt) state_next = CALC;
      CALC: if (idx == LAST_IDX) state_next = FIN;
      FIN:  state_next = DONE;
      DONE: if (ack_add_subt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_add_subt = (state == DONE);
    busy           = (state != IDLE);
  end

  always_comb begin
    slice_a   = op_a[int'(idx)*CHUNK +: CHUNK];
    slice_b   = op_b[int'(idx)*CHUNK +: CHUNK];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry);
  end

  // Subtraction is A + ~B + 1: B is inverted at latch time and the +1 rides in on the initial carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beg_add_subt) begin
            op_a  <= data_a;
            op_b  <= data_b ^ {W{operation_add_subt}};
            carry <= operation_add_subt;
            idx   <= '0;
          end
        end
        CALC: begin
          result[int'(idx)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          carry <= slice_sum[CHUNK];
          idx   <= idx + IDX_W'(1);
        end
        FIN: begin
          overflow <= (op_a[W-1] == op_b[W-1]) && (result[W-1] != op_a[W-1]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_subt_serial_responder.sv
// Bench for add_subt_serial_responder: directed handshake cases plus random operands
// checked against a signed-arithmetic reference model.
`timescale 1ns/1ps
module tb_add_subt_serial_responder;

  localparam int W = 32;
  localparam int N = 4;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         operation_add_subt;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         ready_add_subt;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  add_subt_serial_responder #(.W(W), .CHUNK(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .beg_add_subt       (beg_add_subt),
    .ack_add_subt       (ack_add_subt),
    .operation_add_subt (operation_add_subt),
    .data_a             (data_a),
    .data_b             (data_b),
    .ready_add_subt     (ready_add_subt),
    .result             (result),
    .overflow           (overflow),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed arithmetic, overflow when the true value leaves the W-bit range.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                                output logic [W-1:0] r, output logic v);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = o ? (sa - sb) : (sa + sb);
    r  = s[W-1:0];
    v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    data_a = a;
    data_b = b;
    operation_add_subt = o;
    beg_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int already);
    int cnt;
    cnt = already;
    while (!ready_add_subt && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(LAT));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic o);
    logic [W-1:0] r;
    logic v;
    model(a, b, o, r, v);
    chk({tag, "_result"}, result, r);
    chk({tag, "_ovf"}, 32'(overflow), 32'(v));
  endtask

  task automatic ack_once(input string tag);
    ack_add_subt = 1'b1;
    step();
    ack_add_subt = 1'b0;
    chk({tag, "_ready_drop"}, 32'(ready_add_subt), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic o);
    start(a, b, o);
    wait_ready(tag, 0);
    check_result(tag, a, b, o);
    ack_once(tag);
  endtask

  task automatic test_basic(input string tag);
    start(32'h5, 32'h3, 1'b0);
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_ready_e0"}, 32'(ready_add_subt), 32'd0);
    wait_ready(tag, 0);
    chk({tag, "_result"}, result, 32'h8);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    ack_add_subt = 1'b1;
    step();
    chk({tag, "_ready_ack1"}, 32'(ready_add_subt), 32'd0);
    step();
    ack_add_subt = 1'b0;
    chk({tag, "_ready_ack2"}, 32'(ready_add_subt), 32'd0);
    chk({tag, "_busy_ack2"}, 32'(busy), 32'd0);
    chk({tag, "_result_held"}, result, 32'h8);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         ro;
    logic [W-1:0] keep_res;
    logic         keep_ovf;
    int           drops;

    reset = 1'b0;
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    operation_add_subt = 1'b0;
    data_a = '0;
    data_b = '0;
    #12;
    chk("rst_ready", 32'(ready_add_subt), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();

    test_basic("t1");

    do_op("carry_slice", 32'h000000FF, 32'h00000001, 1'b0);
    chk("carry_slice_val", result, 32'h00000100);
    do_op("sub_wrap", 32'h00000000, 32'h00000001, 1'b1);
    do_op("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    do_op("ovf_neg", 32'h80000000, 32'h00000001, 1'b1);
    do_op("neg_add", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op("sub_minint", 32'h00000000, 32'h80000000, 1'b1);

    // beg during CALC and DONE ignored; ack during CALC ignored; DONE held without ack
    start(32'h12345678, 32'h0F0F0F0F, 1'b1);
    ack_add_subt = 1'b1;
    step();
    ack_add_subt = 1'b0;
    data_a = 32'hDEADBEEF;
    data_b = 32'h11111111;
    operation_add_subt = 1'b0;
    beg_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
    wait_ready("hold", 2);
    check_result("hold", 32'h12345678, 32'h0F0F0F0F, 1'b1);
    keep_res = result;
    keep_ovf = overflow;
    drops = 0;
    data_a = 32'hCAFEF00D;
    beg_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
    if (!ready_add_subt) drops++;
    for (int i = 0; i < 9; i++) begin
      step();
      if (!ready_add_subt || result !== keep_res || overflow !== keep_ovf) drops++;
    end
    chk("hold_stable", 32'(drops), 32'd0);
    check_result("hold_after", 32'h12345678, 32'h0F0F0F0F, 1'b1);
    chk("hold_busy", 32'(busy), 32'd1);
    ack_once("hold");

    // beg and ack together in DONE: ack wins, then restart on the next cycle
    start(32'h00001000, 32'h00000234, 1'b0);
    wait_ready("both", 0);
    check_result("both", 32'h00001000, 32'h00000234, 1'b0);
    data_a = 32'h55555555;
    data_b = 32'h22222222;
    operation_add_subt = 1'b1;
    beg_add_subt = 1'b1;
    ack_add_subt = 1'b1;
    step();
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    chk("both_ready", 32'(ready_add_subt), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_res_kept", result, 32'h00001234);
    do_op("b2b", 32'h55555555, 32'h22222222, 1'b1);

    // async reset in the middle of CALC (slice index 2)
    start(32'hFFFFFFFF, 32'h00000001, 1'b0);
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_add_subt), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b1;
    step();
    test_basic("t1_after_rst");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb[W-1] = ro ? ~ra[W-1] : ra[W-1];
      do_op($sformatf("rnd%0d", i), ra, rb, ro);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
